// File: rtl/stream_downsize_if.sv
// AXI-Stream style channel bundle shared by the wide and narrow sides of a link.
// Latency: none, wires only.
// Backpressure: t_ready flows opposite to t_valid and the payload.
interface stream_channel #(
   parameter int ID_WIDTH   = 1,
   parameter int DATA_WIDTH = 64,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1
) ();
   logic                      t_valid;
   logic                      t_ready;
   logic [ID_WIDTH-1:0]       t_id;
   logic [DEST_WIDTH-1:0]     t_dest;
   logic [USER_WIDTH-1:0]     t_user;
   logic                      t_last;
   logic [DATA_WIDTH-1:0]     t_data;
   logic [DATA_WIDTH/8-1:0]   t_strb;
   logic [DATA_WIDTH/8-1:0]   t_keep;

   modport master (
      output t_valid, t_id, t_dest, t_user, t_last, t_data, t_strb, t_keep,
      input  t_ready
   );

   modport slave (
      input  t_valid, t_id, t_dest, t_user, t_last, t_data, t_strb, t_keep,
      output t_ready
   );
endinterface

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: splits each wide beat into its non-empty lanes, lowest first.
// Latency: first sub-beat is presented the cycle after the wide beat is accepted.
// Backpressure: input is accepted only when empty or when the final sub-beat handshakes.
module stream_downsize #(
   parameter int ID_WIDTH   = 1,
   parameter int IN_WIDTH   = 64,
   parameter int OUT_WIDTH  = 16,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1
) (
   input  logic         clk,
   input  logic         rstn,
   stream_channel.slave  master,
   stream_channel.master slave
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int IKW   = IN_WIDTH / 8;
   localparam int OKW   = OUT_WIDTH / 8;
   localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   // Reject unusable parameterisations and mismatched channel widths before anything is built.
   if ((IN_WIDTH % 8) != 0 || (OUT_WIDTH % 8) != 0 || OUT_WIDTH <= 0) begin : g_bad_byte_width
      $fatal(1, "stream_downsize: data widths must be non-zero multiples of 8");
   end
   if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $fatal(1, "stream_downsize: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
   end
   if ($bits(master.t_data) != IN_WIDTH || $bits(slave.t_data) != OUT_WIDTH ||
       $bits(master.t_id) != ID_WIDTH || $bits(slave.t_id) != ID_WIDTH ||
       $bits(master.t_dest) != DEST_WIDTH || $bits(slave.t_dest) != DEST_WIDTH ||
       $bits(master.t_user) != USER_WIDTH || $bits(slave.t_user) != USER_WIDTH) begin : g_bad_if_width
      $fatal(1, "stream_downsize: channel widths do not match parameters");
   end

   // Holding register: control state is reset, payload is not.
   logic                    full_q, full_d;
   logic [RATIO-1:0]        mask_q, mask_d;
   logic [IN_WIDTH-1:0]     data_q, data_d;
   logic [IKW-1:0]          strb_q, strb_d;
   logic [IKW-1:0]          keep_q, keep_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [DEST_WIDTH-1:0]   dest_q, dest_d;
   logic [USER_WIDTH-1:0]   user_q, user_d;
   logic                    last_q, last_d;

   logic [RATIO-1:0]        in_mask;
   logic [RATIO-1:0]        in_load_mask;
   logic                    in_emits;
   logic [RATIO-1:0]        low_bit;
   logic [LW-1:0]           lane;
   logic                    final_sub;
   logic                    in_rdy;
   logic                    in_hs;
   logic                    out_hs;

   // Lane occupancy of the incoming wide beat; an all-empty closing beat still owes one sub-beat on lane 0.
   always_comb begin
      in_mask = '0;
      for (int k = 0; k < RATIO; k++) begin
         in_mask[k] = |master.t_keep[k*OKW +: OKW];
      end
      in_emits     = (in_mask != '0) || master.t_last;
      in_load_mask = (in_mask != '0) ? in_mask : RATIO'(1);
   end

   // Current lane is the lowest pending bit; final sub-beat is when only one lane remains.
   always_comb begin
      lane = '0;
      for (int k = RATIO - 1; k >= 0; k--) begin
         if (mask_q[k]) begin
            lane = LW'(k);
         end
      end
      low_bit   = mask_q & (~mask_q + RATIO'(1));
      final_sub = full_q && (mask_q != '0) && ((mask_q & (mask_q - RATIO'(1))) == '0);
   end

   // Reload is allowed in the same edge as the final handshake so back-to-back beats have no bubble.
   assign in_rdy = rstn && (!full_q || (final_sub && slave.t_ready));
   assign in_hs  = master.t_valid && in_rdy;
   assign out_hs = full_q && slave.t_ready;

   assign master.t_ready = in_rdy;
   assign slave.t_valid  = full_q;
   assign slave.t_data   = data_q[lane*OUT_WIDTH +: OUT_WIDTH];
   assign slave.t_strb   = strb_q[lane*OKW +: OKW];
   assign slave.t_keep   = keep_q[lane*OKW +: OKW];
   assign slave.t_id     = id_q;
   assign slave.t_dest   = dest_q;
   assign slave.t_user   = user_q;
   assign slave.t_last   = last_q && final_sub;

   // Next holding-register contents: retire the current lane on handshake, load a new beat on acceptance.
   always_comb begin
      full_d = full_q;
      mask_d = mask_q;
      data_d = data_q;
      strb_d = strb_q;
      keep_d = keep_q;
      id_d   = id_q;
      dest_d = dest_q;
      user_d = user_q;
      last_d = last_q;
      if (out_hs) begin
         mask_d = mask_q & ~low_bit;
         if ((mask_q & ~low_bit) == '0) begin
            full_d = 1'b0;
         end
      end
      // A non-last beat with no kept bytes is swallowed here without touching the state.
      if (in_hs && in_emits) begin
         full_d = 1'b1;
         mask_d = in_load_mask;
         data_d = master.t_data;
         strb_d = master.t_strb;
         keep_d = master.t_keep;
         id_d   = master.t_id;
         dest_d = master.t_dest;
         user_d = master.t_user;
         last_d = master.t_last;
      end
   end

   // Control state: reset discards any partially emitted beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_q <= 1'b0;
         mask_q <= '0;
      end else begin
         full_q <= full_d;
         mask_q <= mask_d;
      end
   end

   // Payload: only meaningful while full, so it carries no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      strb_q <= strb_d;
      keep_q <= keep_d;
      id_q   <= id_d;
      dest_q <= dest_d;
      user_q <= user_d;
      last_q <= last_d;
   end

endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize: directed cases plus random traffic against a lane-expansion model.
// Latency: n/a.
// Backpressure: slave ready is held high or randomised per phase.
module tb_stream_downsize;

   localparam int IW = 64;
   localparam int OW = 16;
   localparam int XW = 2;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  strb;
      logic [1:0]  keep;
      logic [1:0]  id;
      logic [1:0]  dest;
      logic [1:0]  user;
      logic        last;
   } ob_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;

   stream_channel #(.ID_WIDTH(XW), .DATA_WIDTH(IW), .DEST_WIDTH(XW), .USER_WIDTH(XW)) in_if ();
   stream_channel #(.ID_WIDTH(XW), .DATA_WIDTH(OW), .DEST_WIDTH(XW), .USER_WIDTH(XW)) out_if ();

   stream_downsize #(
      .ID_WIDTH(XW), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEST_WIDTH(XW), .USER_WIDTH(XW)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .master (in_if),
      .slave  (out_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   ob_t exp_q[$];
   ob_t obs_q[$];
   int cyc = 0;
   int rdy_low = 0;
   int out_cnt = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   logic bp_en = 1'b0;
   logic stall = 1'b0;
   logic [27:0] snap;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: each wide beat becomes its kept lanes in ascending order; an empty last beat becomes one lane-0 marker.
   task automatic expand(input logic [63:0] d, input logic [7:0] s, input logic [7:0] k, input logic l,
                         input logic [1:0] id, input logic [1:0] de, input logic [1:0] us);
      int last_lane;
      ob_t b;
      last_lane = -1;
      for (int i = 0; i < 4; i++) if (k[2*i +: 2] != 2'b00) last_lane = i;
      if (last_lane < 0) begin
         if (l) begin
            b = '{data: d[15:0], strb: s[1:0], keep: 2'b00, id: id, dest: de, user: us, last: 1'b1};
            exp_q.push_back(b);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (k[2*i +: 2] != 2'b00) begin
               b = '{data: d[16*i +: 16], strb: s[2*i +: 2], keep: k[2*i +: 2], id: id, dest: de,
                     user: us, last: (l && i == last_lane)};
               exp_q.push_back(b);
            end
         end
      end
   endtask

   function automatic ob_t cur_beat();
      ob_t b;
      b = '{data: out_if.t_data, strb: out_if.t_strb, keep: out_if.t_keep, id: out_if.t_id,
            dest: out_if.t_dest, user: out_if.t_user, last: out_if.t_last};
      return b;
   endfunction

   // Monitor at the falling edge: scoreboard output handshakes, check stall stability, feed the model.
   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         stall = 1'b0;
      end else begin
         if (stall) chk("stable", {36'd0, out_if.t_valid, cur_beat()}, {36'd0, snap});
         if (out_if.t_valid && out_if.t_ready) begin
            if (out_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            out_cnt++;
            obs_q.push_back(cur_beat());
            if (exp_q.size() == 0) chk("unexpected_beat", 64'(cur_beat()), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("beat", 64'(cur_beat()), 64'(exp_q.pop_front()));
         end
         stall = out_if.t_valid && !out_if.t_ready;
         snap  = {1'b1, cur_beat()};
         if (in_if.t_valid && in_if.t_ready)
            expand(in_if.t_data, in_if.t_strb, in_if.t_keep, in_if.t_last, in_if.t_id, in_if.t_dest, in_if.t_user);
         if (!in_if.t_ready) rdy_low++;
         cyc++;
      end
   end

   // Slave ready: always high unless the random backpressure phase is on.
   initial begin
      out_if.t_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_if.t_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat has been taken, valid still high.
   task automatic send(input logic [63:0] d, input logic [7:0] s, input logic [7:0] k, input logic l,
                       input logic [1:0] id, input logic [1:0] de, input logic [1:0] us);
      int n;
      in_if.t_valid = 1'b1;
      in_if.t_data = d; in_if.t_strb = s; in_if.t_keep = k; in_if.t_last = l;
      in_if.t_id = id; in_if.t_dest = de; in_if.t_user = us;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_if.t_ready && n < 300);
      if (!in_if.t_ready) chk("send_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_if.t_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      in_if.t_valid = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || out_if.t_valid) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000) chk("drain_timeout", 64'd1, 64'd0);
      idle(3);
   endtask

   localparam logic [63:0] DEF_DATA = 64'h8877_6655_4433_2211;

   initial begin
      logic [15:0] def_exp [4];
      logic [7:0]  rk;
      int n;
      def_exp[0] = 16'h2211; def_exp[1] = 16'h4433; def_exp[2] = 16'h6655; def_exp[3] = 16'h8877;
      in_if.t_valid = 1'b0; in_if.t_data = '0; in_if.t_strb = '0; in_if.t_keep = '0;
      in_if.t_last = 1'b0; in_if.t_id = '0; in_if.t_dest = '0; in_if.t_user = '0;

      #3;
      chk("rst_out_valid", 64'(out_if.t_valid), 64'd0);
      chk("rst_in_ready", 64'(in_if.t_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'(in_if.t_ready), 64'd1);
      chk("post_rst_out_valid", 64'(out_if.t_valid), 64'd0);

      // Full beat, all lanes kept.
      obs_q.delete(); rdy_low = 0;
      send(DEF_DATA, 8'hFF, 8'hFF, 1'b1, 2'd1, 2'd2, 2'd3);
      drain();
      chk("def_count", 64'(obs_q.size()), 64'd4);
      chk("def_rdy_low", 64'(rdy_low), 64'd3);
      if (obs_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("def_data", 64'(obs_q[i].data), 64'(def_exp[i]));
            chk("def_keep", 64'(obs_q[i].keep), 64'd3);
            chk("def_last", 64'(obs_q[i].last), 64'(i == 3));
         end
      end

      // Sparse keep: lanes 0 and 3 only.
      obs_q.delete();
      send(DEF_DATA, 8'hC3, 8'hC3, 1'b1, 2'd0, 2'd1, 2'd0);
      drain();
      chk("sparse_count", 64'(obs_q.size()), 64'd2);
      if (obs_q.size() == 2) begin
         chk("sparse_d0", 64'(obs_q[0].data), 64'h2211);
         chk("sparse_d1", 64'(obs_q[1].data), 64'h8877);
         chk("sparse_k1", 64'(obs_q[1].keep), 64'd3);
         chk("sparse_l0", 64'(obs_q[0].last), 64'd0);
         chk("sparse_l1", 64'(obs_q[1].last), 64'd1);
      end

      // Empty non-last beat is swallowed.
      obs_q.delete(); rdy_low = 0;
      send(DEF_DATA, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      drain();
      chk("empty_nolast_count", 64'(obs_q.size()), 64'd0);
      chk("empty_nolast_rdy", 64'(rdy_low), 64'd0);

      // Empty last beat gives one zero-keep terminator.
      obs_q.delete();
      send(DEF_DATA, 8'h00, 8'h00, 1'b1, 2'd2, 2'd0, 2'd1);
      drain();
      chk("empty_last_count", 64'(obs_q.size()), 64'd1);
      if (obs_q.size() == 1) begin
         chk("empty_last_keep", 64'(obs_q[0].keep), 64'd0);
         chk("empty_last_last", 64'(obs_q[0].last), 64'd1);
         chk("empty_last_data", 64'(obs_q[0].data), 64'h2211);
      end

      // Sixteen back-to-back full beats.
      obs_q.delete(); out_cnt = 0;
      for (int i = 0; i < 16; i++)
         send({$urandom, $urandom}, 8'hFF, 8'hFF, 1'(i % 3 == 2), 2'(i), 2'(i >> 2), 2'(i + 1));
      drain();
      chk("tput_count", 64'(out_cnt), 64'd64);
      chk("tput_span", 64'(last_cyc - first_cyc), 64'd63);

      // Random traffic with random backpressure.
      bp_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: rk = 8'h00;
            1: rk = 8'hFF;
            default: rk = 8'($urandom);
         endcase
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send({$urandom, $urandom}, 8'($urandom), rk, 1'($urandom_range(0, 1)),
              2'($urandom), 2'($urandom), 2'($urandom));
      end
      drain();
      chk("bp_leftover", 64'(exp_q.size()), 64'd0);
      bp_en = 1'b0;
      idle(2);

      // Reset in the middle of a four-lane beat.
      obs_q.delete();
      send(DEF_DATA, 8'hFF, 8'hFF, 1'b1, 2'd1, 2'd1, 2'd1);
      in_if.t_valid = 1'b0;
      n = 0;
      while (obs_q.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (obs_q.size() < 2) chk("mid_rst_wait", 64'(obs_q.size()), 64'd2);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_if.t_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_if.t_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rel_ready", 64'(in_if.t_ready), 64'd1);
      chk("rel_valid", 64'(out_if.t_valid), 64'd0);
      @(posedge clk);
      #1;
      obs_q.delete();
      send(DEF_DATA, 8'hFF, 8'hFF, 1'b1, 2'd3, 2'd3, 2'd3);
      drain();
      chk("after_rst_count", 64'(obs_q.size()), 64'd4);
      if (obs_q.size() >= 1) chk("after_rst_lane0", 64'(obs_q[0].data), 64'h2211);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
